uart_tx_fifo: RTL and testbench

Buffered 8N1 UART transmitter for the MCU's outbound serial port. It accepts bytes from the CPU-side write strobe into a small FIFO and serialises them LSB-first on `tx` at a fixed baud rate. It is the sending counterpart of the bench-side and MCU-side UART receivers, and lets firmware queue several characters without polling per byte.

---
 rtl/uart_tx_fifo_if.sv | 32 +++
 rtl/uart_tx_fifo.sv | 150 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// CPU-side bundle of the buffered UART transmitter: write strobe/data in, line and status out.
// The count width tracks the FIFO depth so occupancy 0..DEPTH fits.
interface uart_tx_fifo_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [7:0]    tx_data;
  logic          wr;
  logic          tx_ready;
  logic          tx;
  logic          busy;
  logic [CW-1:0] count;

  modport master (
    output tx_data,
    output wr,
    input  tx_ready,
    input  tx,
    input  busy,
    input  count
  );

  modport slave (
    input  tx_data,
    input  wr,
    output tx_ready,
    output tx,
    output busy,
    output count
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes queue in a small FIFO and go out LSB-first on tx.
// Frames are exactly 10*DIV cycles and follow each other without an idle gap.
module uart_tx_fifo #(
  parameter int unsigned CLOCK_HZ = 100_000,
  parameter int unsigned BAUD     = 1_000,
  parameter int unsigned DEPTH    = 8
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_fifo_if.slave  bus
);
  localparam int unsigned DIV = CLOCK_HZ / BAUD;
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned BW  = $clog2(DIV);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;

  logic push, pop, not_full, not_empty, baud_end;

  assign not_full  = count_q < CW'(DEPTH);
  assign not_empty = count_q != '0;
  // Full is judged on the pre-edge count, so a same-cycle pop never frees room for the write.
  assign push      = bus.wr && not_full;
  assign baud_end  = baud_q == BW'(DIV - 1);

  always_comb begin
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.tx_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (not_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          tx_d    = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          state_d = StData;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      StData: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      StStop: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next start bit when more data is waiting.
          if (not_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign bus.tx       = tx_q;
  assign bus.tx_ready = not_full;
  assign bus.busy     = (state_q != StIdle) || not_empty;
  assign bus.count    = count_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a DIV=4 instance for FIFO/framing/reset cases and a
// default-parameter instance for the DIV=100 frame timing.
module tb_uart_tx_fifo;
  localparam int DIVA  = 4;
  localparam int DIVB  = 100;
  localparam int DEPTH = 8;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   checks;
  int   errors;
  int   cyc;

  logic [7:0] rx_q [$];
  int         rx_start [$];

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus_a ();
  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus_b ();

  uart_tx_fifo #(
    .CLOCK_HZ (16),
    .BAUD     (4),
    .DEPTH    (DEPTH)
  ) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a.slave)
  );

  uart_tx_fifo dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_rx(input int n, input int budget, input string tag);
    int t = 0;
    while (rx_q.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(tag, rx_q.size(), n);
  endtask

  // Bench receiver for the DIV=4 line: mid-bit sampling on negedges, frames dropped on reset.
  initial begin
    int         cnt;
    logic       active;
    logic [7:0] sh;
    cnt    = 0;
    active = 1'b0;
    sh     = '0;
    forever begin
      @(negedge clk);
      if (!rst_a) begin
        active = 1'b0;
      end else if (!active) begin
        if (bus_a.tx === 1'b0) begin
          active = 1'b1;
          cnt    = 0;
          rx_start.push_back(cyc);
        end
      end else begin
        cnt++;
        for (int i = 0; i < 8; i++) begin
          if (cnt == DIVA * (i + 1) + DIVA / 2) sh[i] = bus_a.tx;
        end
        if (cnt == 9 * DIVA + DIVA / 2) begin
          check("rx_stop_bit", bus_a.tx, 1);
          rx_q.push_back(sh);
          active = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [7:0] d;
    logic [7:0] exp_bytes [10];
    int         bitidx;
    int         e;
    int         peak;
    int         bad;
    int         lows;
    int         t;
    int         run;
    logic       in_run;
    logic [7:0] dec;
    logic       stop_b;
    logic       busy999;
    logic       busy1000;

    checks = 0;
    errors = 0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    bus_a.wr = 1'b0;
    bus_a.tx_data = '0;
    bus_b.wr = 1'b0;
    bus_b.tx_data = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx", bus_a.tx, 1);
    check("rst_ready", bus_a.tx_ready, 1);
    check("rst_busy", bus_a.busy, 0);
    check("rst_count", bus_a.count, 0);
    check("rst_b_tx", bus_b.tx, 1);
    check("rst_b_ready", bus_b.tx_ready, 1);
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single 0x55 frame, cycle-exact line shape
    d = 8'h55;
    bus_a.wr = 1'b1;
    bus_a.tx_data = d;
    @(negedge clk);
    bus_a.wr = 1'b0;
    check("t1_count", bus_a.count, 1);
    check("t1_tx_pre", bus_a.tx, 1);
    check("t1_busy", bus_a.busy, 1);
    for (int j = 0; j < 10 * DIVA; j++) begin
      @(negedge clk);
      bitidx = j / DIVA;
      if (bitidx == 0) e = 0;
      else if (bitidx == 9) e = 1;
      else e = int'(d[bitidx-1]);
      check("t1_line", bus_a.tx, e);
    end
    check("t1_busy_last", bus_a.busy, 1);
    @(negedge clk);
    check("t1_busy_end", bus_a.busy, 0);
    check("t1_tx_idle", bus_a.tx, 1);
    wait_rx(1, 20, "t1_rx_n");
    check("t1_rx_byte", rx_q[0], 8'h55);
    rx_q.delete();
    rx_start.delete();

    // 2: three back-to-back bytes
    repeat (5) @(negedge clk);
    bus_a.wr = 1'b1;
    bus_a.tx_data = 8'h41;
    @(negedge clk);
    check("t2_cnt0", bus_a.count, 1);
    bus_a.tx_data = 8'h42;
    @(negedge clk);
    check("t2_cnt1", bus_a.count, 1);
    bus_a.tx_data = 8'h43;
    @(negedge clk);
    bus_a.wr = 1'b0;
    peak = 0;
    for (int j = 0; j < 118; j++) begin
      if (int'(bus_a.count) > peak) peak = int'(bus_a.count);
      @(negedge clk);
    end
    check("t2_peak", peak, 2);
    check("t2_busy_last", bus_a.busy, 1);
    @(negedge clk);
    check("t2_busy_end", bus_a.busy, 0);
    wait_rx(3, 20, "t2_rx_n");
    if (rx_q.size() == 3 && rx_start.size() == 3) begin
      check("t2_b0", rx_q[0], 8'h41);
      check("t2_b1", rx_q[1], 8'h42);
      check("t2_b2", rx_q[2], 8'h43);
      check("t2_gap01", rx_start[1] - rx_start[0], 10 * DIVA);
      check("t2_gap12", rx_start[2] - rx_start[1], 10 * DIVA);
    end
    rx_q.delete();
    rx_start.delete();

    // 3: ten writes into an 8-deep FIFO, one dropped; 4: full + pop + write
    repeat (5) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      bus_a.wr = 1'b1;
      bus_a.tx_data = 8'(i);
      @(negedge clk);
      e = (i == 0) ? 1 : ((i <= 8) ? i : 8);
      check("t3_count", bus_a.count, e);
      check("t3_ready", bus_a.tx_ready, (e < DEPTH) ? 1 : 0);
    end
    bus_a.wr = 1'b0;
    repeat (31) @(negedge clk);
    check("t4_full", bus_a.count, 8);
    bus_a.wr = 1'b1;
    bus_a.tx_data = 8'hAA;
    @(negedge clk);
    check("t4_rejected", bus_a.count, 7);
    check("t4_ready", bus_a.tx_ready, 1);
    @(negedge clk);
    bus_a.wr = 1'b0;
    check("t4_accepted", bus_a.count, 8);
    wait_rx(10, 500, "t3_rx_n");
    for (int i = 0; i < 9; i++) exp_bytes[i] = 8'(i);
    exp_bytes[9] = 8'hAA;
    if (rx_q.size() == 10 && rx_start.size() == 10) begin
      for (int i = 0; i < 10; i++) check("t3_byte", rx_q[i], exp_bytes[i]);
      bad = 0;
      for (int i = 1; i < 10; i++) if (rx_start[i] - rx_start[i-1] != 10 * DIVA) bad++;
      check("t3_gaps", bad, 0);
    end
    t = 0;
    while (bus_a.busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("t3_drain", bus_a.busy, 0);
    rx_q.delete();
    rx_start.delete();

    // 5: async reset in the middle of data bit 3 of 0xF0
    repeat (3) @(negedge clk);
    bus_a.wr = 1'b1;
    bus_a.tx_data = 8'hF0;
    @(negedge clk);
    bus_a.tx_data = 8'h11;
    @(negedge clk);
    bus_a.tx_data = 8'h22;
    @(negedge clk);
    bus_a.tx_data = 8'h33;
    @(negedge clk);
    bus_a.wr = 1'b0;
    check("t5_queued", bus_a.count, 3);
    repeat (15) @(negedge clk);
    check("t5_bit3", bus_a.tx, 0);
    #2;
    rst_a = 1'b0;
    #1;
    check("t5_rst_tx", bus_a.tx, 1);
    check("t5_rst_count", bus_a.count, 0);
    check("t5_rst_busy", bus_a.busy, 0);
    check("t5_rst_ready", bus_a.tx_ready, 1);
    bus_a.wr = 1'b1;
    bus_a.tx_data = 8'h99;
    repeat (3) @(negedge clk);
    bus_a.wr = 1'b0;
    check("t5_wr_ignored", bus_a.count, 0);
    rst_a = 1'b1;
    lows = 0;
    for (int j = 0; j < 80; j++) begin
      @(negedge clk);
      if (bus_a.tx !== 1'b1) lows++;
    end
    check("t5_quiet", lows, 0);
    check("t5_no_rx", rx_q.size(), 0);
    check("t5_idle_busy", bus_a.busy, 0);

    // 6: default parameters, DIV=100, byte 0x04
    bus_b.wr = 1'b1;
    bus_b.tx_data = 8'h04;
    @(negedge clk);
    bus_b.wr = 1'b0;
    check("t6_count", bus_b.count, 1);
    t = 0;
    while (bus_b.tx !== 1'b0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("t6_latency", t, 1);
    run = 0;
    in_run = 1'b1;
    dec = '0;
    stop_b = 1'b0;
    busy999 = 1'b0;
    busy1000 = 1'b1;
    for (int idx = 0; idx <= 10 * DIVB; idx++) begin
      if (idx > 0) @(negedge clk);
      if (in_run && bus_b.tx === 1'b0) run++;
      else in_run = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (idx == DIVB * (i + 1) + DIVB / 2) dec[i] = bus_b.tx;
      end
      if (idx == 9 * DIVB + DIVB / 2) stop_b = bus_b.tx;
      if (idx == 10 * DIVB - 1) busy999 = bus_b.busy;
      if (idx == 10 * DIVB) busy1000 = bus_b.busy;
    end
    // Start bit plus data bits 0 and 1 of 0x04 are all low.
    check("t6_low_run", run, 3 * DIVB);
    check("t6_byte", dec, 8'h04);
    check("t6_stop", stop_b, 1);
    check("t6_busy_last", busy999, 1);
    check("t6_busy_end", busy1000, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
